// File: rtl/debug_frame_tx_pkg.sv
// Shared definitions for the debug frame transmitter: default header byte,
// frame geometry, serialiser state encoding and the frame checksum helper.
package debug_frame_tx_pkg;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
  localparam int         FRAME_LEN      = 9;
  localparam int         PORT_COUNT     = 7;
  // Index of the checksum byte, i.e. the last byte of a frame.
  localparam logic [3:0] LAST_BYTE_IDX  = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA      = 2'd2,
    STOP_BIT  = 2'd3
  } tx_state_e;

  // Captured debug bytes; element 0 holds debug_port1.
  typedef logic [PORT_COUNT-1:0][7:0] snapshot_t;

  // XOR of all captured bytes, sent as the closing byte of a frame.
  function automatic logic [7:0] xor_checksum(input snapshot_t snap);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < PORT_COUNT; i++) begin
      acc = acc ^ snap[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/debug_frame_tx_uart_tx_byte.sv
// Single-byte UART 8N1 serialiser. A load accepted in IDLE, or in the final
// cycle of a stop bit, starts the next byte with no idle time in between.
// byte_done marks the last cycle of the stop bit so the sequencer can chain
// the following byte on the same edge.
module uart_tx_byte
  import debug_frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] tx_byte,
  input  logic       load,
  output logic       tx,
  output logic       byte_done
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_r, state_n;
  logic [CW-1:0] bit_cnt_r, bit_cnt_n;
  logic [2:0]    bit_idx_r, bit_idx_n;
  logic [7:0]    shift_r, shift_n;
  logic          tx_r, tx_n;
  logic          last_tick_s;

  assign last_tick_s = (bit_cnt_r == LAST_TICK);
  assign byte_done   = (state_r == STOP_BIT) && last_tick_s;
  assign tx          = tx_r;

  // State, timing counters, shifter and the registered serial line.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r   <= IDLE;
      bit_cnt_r <= CW'(0);
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
    end else begin
      state_r   <= state_n;
      bit_cnt_r <= bit_cnt_n;
      bit_idx_r <= bit_idx_n;
      shift_r   <= shift_n;
      tx_r      <= tx_n;
    end
  end

  // Next-state logic; tx_n is the line level for the coming cycle.
  always_comb begin
    state_n   = state_r;
    bit_cnt_n = bit_cnt_r;
    bit_idx_n = bit_idx_r;
    shift_n   = shift_r;
    tx_n      = tx_r;
    case (state_r)
      IDLE: begin
        bit_cnt_n = CW'(0);
        bit_idx_n = 3'd0;
        if (load) begin
          state_n = START_BIT;
          shift_n = tx_byte;
          tx_n    = 1'b0;
        end else begin
          tx_n    = 1'b1;
        end
      end
      START_BIT: begin
        if (last_tick_s) begin
          bit_cnt_n = CW'(0);
          bit_idx_n = 3'd0;
          state_n   = DATA;
          tx_n      = shift_r[0];
        end else begin
          bit_cnt_n = bit_cnt_r + CW'(1);
        end
      end
      DATA: begin
        if (last_tick_s) begin
          bit_cnt_n = CW'(0);
          if (bit_idx_r == 3'd7) begin
            state_n   = STOP_BIT;
            bit_idx_n = 3'd0;
            tx_n      = 1'b1;
          end else begin
            bit_idx_n = bit_idx_r + 3'd1;
            shift_n   = {1'b0, shift_r[7:1]};
            tx_n      = shift_r[1];
          end
        end else begin
          bit_cnt_n = bit_cnt_r + CW'(1);
        end
      end
      STOP_BIT: begin
        if (last_tick_s) begin
          bit_cnt_n = CW'(0);
          if (load) begin
            state_n = START_BIT;
            shift_n = tx_byte;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          bit_cnt_n = bit_cnt_r + CW'(1);
        end
      end
      default: begin
        state_n   = IDLE;
        bit_cnt_n = CW'(0);
        bit_idx_n = 3'd0;
        tx_n      = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/debug_frame_tx.sv
// Debug frame transmitter: on an accepted start, snapshots seven debug bytes
// and sends HEADER, the seven bytes and their XOR checksum as one
// back-to-back UART 8N1 burst.
module debug_frame_tx
  import debug_frame_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HEADER       = DEFAULT_HEADER
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  snapshot_t  snap_r, snap_n;
  snapshot_t  ports_s;
  logic [3:0] byte_idx_r, byte_idx_n;
  logic [3:0] next_idx_s;
  logic       busy_r, busy_n;
  logic       frame_done_r, frame_done_n;
  logic       accept_s, load_s, byte_done_s;
  logic [7:0] tx_byte_s, next_byte_s, chk_s;

  assign ports_s    = {debug_port7, debug_port6, debug_port5, debug_port4,
                       debug_port3, debug_port2, debug_port1};
  assign chk_s      = xor_checksum(snap_r);
  assign accept_s   = start && !busy_r;
  assign next_idx_s = byte_idx_r + 4'd1;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk      (clk),
    .nreset   (nreset),
    .tx_byte  (tx_byte_s),
    .load     (load_s),
    .tx       (tx),
    .byte_done(byte_done_s)
  );

  // Frame byte that follows the one currently on the line.
  always_comb begin
    next_byte_s = HEADER;
    case (next_idx_s)
      4'd1:    next_byte_s = snap_r[0];
      4'd2:    next_byte_s = snap_r[1];
      4'd3:    next_byte_s = snap_r[2];
      4'd4:    next_byte_s = snap_r[3];
      4'd5:    next_byte_s = snap_r[4];
      4'd6:    next_byte_s = snap_r[5];
      4'd7:    next_byte_s = snap_r[6];
      4'd8:    next_byte_s = chk_s;
      default: next_byte_s = HEADER;
    endcase
  end

  // Frame sequencing: accept, chain bytes on byte_done, close after CHK.
  always_comb begin
    load_s       = 1'b0;
    tx_byte_s    = HEADER;
    byte_idx_n   = byte_idx_r;
    busy_n       = busy_r;
    frame_done_n = 1'b0;
    snap_n       = snap_r;
    if (accept_s) begin
      load_s     = 1'b1;
      tx_byte_s  = HEADER;
      byte_idx_n = 4'd0;
      busy_n     = 1'b1;
      snap_n     = ports_s;
    end else if (busy_r && byte_done_s) begin
      if (byte_idx_r < LAST_BYTE_IDX) begin
        load_s     = 1'b1;
        tx_byte_s  = next_byte_s;
        byte_idx_n = next_idx_s;
      end else begin
        busy_n       = 1'b0;
        frame_done_n = 1'b1;
      end
    end else begin
      busy_n = busy_r;
    end
  end

  // Snapshot, byte index and status flags.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      snap_r       <= '{default: 8'h00};
      byte_idx_r   <= 4'd0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      snap_r       <= snap_n;
      byte_idx_r   <= byte_idx_n;
      busy_r       <= busy_n;
      frame_done_r <= frame_done_n;
    end
  end

endmodule
